// File: rtl/up_down_counter_param.sv
// up_down_counter_param: parametrised up/down counter with load, enable and WRAP/SAT/PINGPONG/ONESHOT end modes
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   en, updown      count enable, requested direction (1 = up)
//   mode            0 WRAP, 1 SAT, 2 PINGPONG, 3 ONESHOT
//   load, load_val  synchronous parallel load (clamped to MAX_VAL)
//   count, dir      registered count and effective direction
//   tc              combinational terminal count in the current direction
//   ovf, unf        one-cycle pulses for steps attempted past MAX_VAL / 0
//   done            sticky ONESHOT completion flag
module up_down_counter_param #(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = 2**WIDTH-1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             updown,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             tc,
    output logic             ovf,
    output logic             unf,
    output logic             done
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);
    localparam logic [1:0] WRAP = 2'd0, PINGPONG = 2'd2, ONESHOT = 2'd3;
    logic [WIDTH-1:0] count_q, count_d, step_val;
    logic dir_q, dir_d, ovf_q, ovf_d, unf_q, unf_d, done_q, done_d;
    logic step_up, at_end, near_end;
    // PINGPONG keeps its own direction; every other mode follows updown
    assign step_up  = (mode == PINGPONG) ? dir_q : updown;
    assign at_end   = step_up ? (count_q == MAX) : (count_q == '0);
    assign near_end = step_up ? (count_q == MAX - WIDTH'(1)) : (count_q == WIDTH'(1));
    assign step_val = step_up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        done_d  = (mode == ONESHOT) && done_q;
        if (load) begin
            count_d = (load_val > MAX) ? MAX : load_val;
            dir_d   = updown;
            done_d  = 1'b0;
        end else if (en) begin
            dir_d = step_up;
            if (mode == ONESHOT) begin
                // once done the count freezes; reaching the endpoint sets done on the same edge
                if (!done_q) begin
                    count_d = at_end ? count_q : step_val;
                    done_d  = at_end || near_end;
                end
            end else if (!at_end) begin
                count_d = step_val;
            end else begin
                ovf_d = step_up;
                unf_d = !step_up;
                if (mode == WRAP) begin
                    count_d = step_up ? '0 : MAX;
                end else if (mode == PINGPONG) begin
                    count_d = step_up ? MAX - WIDTH'(1) : WIDTH'(1);
                    dir_d   = !step_up;
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            dir_q   <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            done_q  <= done_d;
        end
    end
    assign count = count_q;
    assign dir   = dir_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;
    assign done  = done_q;
    assign tc    = dir_q ? (count_q == MAX) : (count_q == '0);
endmodule
